// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_t;

    // One-hot requester vector for a 1-bit requester index.
    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-requester round-robin pick: the requester opposite the last owner
// wins a tie; a lone requester always wins.
module rr_arb2
    import uart_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_owner,
    output logic [NUM_REQ-1:0] grant
);

    // Combinational one-hot grant selection.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_owner ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two word-wide transmit requesters onto a byte-serial UART
// transmitter, sending up to four bytes LSB first with a per-byte timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd65535
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [WORD_W-1:0]   req0_data,
    input  logic [WORD_W-1:0]   req1_data,
    input  logic [1:0]          req0_len,
    input  logic [1:0]          req1_len,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [NUM_REQ-1:0]  done,
    output logic [BYTE_W-1:0]   send_data,
    output logic                Sdata_valid,
    input  logic                Send_fin,
    output logic                busy,
    output logic                err
);

    tx_state_t          state_q, state_nxt;
    logic [WORD_W-1:0]  shift_q;
    logic [1:0]         byte_cnt_q;
    logic               owner_q;
    logic               last_owner_q;
    logic [31:0]        tmo_cnt_q;
    logic [31:0]        tmo_inc;
    logic               err_q;

    logic [NUM_REQ-1:0] rr_grant;
    logic               load;
    logic               shift_en;
    logic               tmo_clr;
    logic               tmo_step;
    logic               err_set;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .grant      (rr_grant)
    );

    assign tmo_inc = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + 32'd1;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        tmo_clr   = 1'b0;
        tmo_step  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                tmo_clr   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (Send_fin) begin
                    if (byte_cnt_q != 2'd0) begin
                        shift_en  = 1'b1;
                        state_nxt = ST_STROBE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (tmo_inc >= TIMEOUT_CYC) begin
                    err_set   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    tmo_step = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transfer datapath: shift register, byte counter, owner, pointer, timeout, error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            if (load) begin
                shift_q      <= rr_grant[1] ? req1_data : req0_data;
                byte_cnt_q   <= rr_grant[1] ? req1_len  : req0_len;
                owner_q      <= rr_grant[1];
                last_owner_q <= rr_grant[1];
                err_q        <= 1'b0;
            end else if (shift_en) begin
                shift_q    <= shift_q >> BYTE_W;
                byte_cnt_q <= byte_cnt_q - 2'd1;
            end
            if (err_set)
                err_q <= 1'b1;
            if (tmo_clr)
                tmo_cnt_q <= '0;
            else if (tmo_step)
                tmo_cnt_q <= tmo_inc;
        end
    end

    // gnt is decoded from IDLE and the live requests, so it is gated by reset
    // to stay low while RST_N is asserted.
    assign gnt         = (state_q == ST_IDLE && RST_N) ? rr_grant : '0;
    assign done        = (state_q == ST_DONE) ? owner_onehot(owner_q) : '0;
    assign send_data   = shift_q[BYTE_W-1:0];
    assign Sdata_valid = (state_q == ST_STROBE);
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with directed and random transfers.
module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  req_valid;
    logic [31:0] req0_data, req1_data;
    logic [1:0]  req0_len, req1_len;
    logic [1:0]  gnt, done;
    logic [7:0]  send_data;
    logic        Sdata_valid, Send_fin, busy, err;

    int total = 0;
    int bad   = 0;
    int favour = 0;
    logic exp_err = 1'b0;

    uart_tx_arbiter #(.TIMEOUT_CYC(32'd16)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req_valid   (req_valid),
        .req0_data   (req0_data),
        .req1_data   (req1_data),
        .req0_len    (req0_len),
        .req1_len    (req1_len),
        .gnt         (gnt),
        .done        (done),
        .send_data   (send_data),
        .Sdata_valid (Sdata_valid),
        .Send_fin    (Send_fin),
        .busy        (busy),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer. Entered on a falling edge with the DUT idle;
    // returns on the falling edge of the first idle cycle after done.
    // delay < 0 means the transmitter never answers (timeout).
    task automatic run_one(input logic [1:0] rv, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] l0, input logic [1:0] l1,
                           input int delay, input bit spur);
        int owner;
        int n;
        logic [31:0] d;
        logic [31:0] b;
        req_valid = rv;
        req0_data = d0; req1_data = d1;
        req0_len  = l0; req1_len  = l1;
        Send_fin  = spur;
        #1;
        owner = (rv == 2'b11) ? favour : ((rv == 2'b10) ? 1 : 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {30'd0, done}, 32'd0);
        chk("idle_err", {31'd0, err}, {31'd0, exp_err});
        chk("gnt", {30'd0, gnt}, 32'd1 << owner);
        d = owner ? d1 : d0;
        n = (owner ? int'(l1) : int'(l0)) + 1;
        favour = 1 - owner;
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            Send_fin = spur && (i == 0);
            if (i == 0) begin
                req_valid[owner] = 1'b0;
                if (owner == 1) begin req1_data = $urandom; req1_len = 2'($urandom); end
                else            begin req0_data = $urandom; req0_len = 2'($urandom); end
            end
            #1;
            b = (d >> (8 * i)) & 32'hFF;
            chk("strobe_valid", {31'd0, Sdata_valid}, 32'd1);
            chk("strobe_byte", {24'd0, send_data}, b);
            chk("strobe_gnt", {30'd0, gnt}, 32'd0);
            if (i == 0) chk("err_cleared", {31'd0, err}, 32'd0);
            if (delay < 0) begin
                for (int c = 1; c <= 16; c++) begin
                    @(negedge CLK);
                    Send_fin = 1'b0;
                    #1;
                    chk("wait_valid", {31'd0, Sdata_valid}, 32'd0);
                    chk("wait_busy", {31'd0, busy}, 32'd1);
                    chk("wait_done", {30'd0, done}, 32'd0);
                end
                break;
            end
            for (int c = 1; c <= delay; c++) begin
                @(negedge CLK);
                Send_fin = (c == delay);
                #1;
                chk("wait_valid", {31'd0, Sdata_valid}, 32'd0);
                chk("wait_busy", {31'd0, busy}, 32'd1);
            end
        end
        @(negedge CLK);
        Send_fin = 1'b0;
        #1;
        if (delay < 0) exp_err = 1'b1;
        chk("done", {30'd0, done}, 32'd1 << owner);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_gnt", {30'd0, gnt}, 32'd0);
        chk("done_valid", {31'd0, Sdata_valid}, 32'd0);
        chk("done_err", {31'd0, err}, {31'd0, exp_err});
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] rd;
        RST_N = 1'b0; req_valid = '0; req0_data = '0; req1_data = '0;
        req0_len = '0; req1_len = '0; Send_fin = 1'b0;
        #2;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_done", {30'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, Sdata_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_data", {24'd0, send_data}, 32'd0);
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Both requesters from reset alternate, starting with requester 0.
        for (int k = 0; k < 4; k++)
            run_one(2'b11, 32'h000000A0 + k, 32'h000000B0 + k, 2'd0, 2'd0, 2, 1'b0);

        // Four-byte word from requester 0, transmitter answers after 5 cycles.
        run_one(2'b01, 32'h44332211, 32'h0, 2'd3, 2'd0, 5, 1'b0);

        // Lone requester 1, then a tie must go back to requester 0.
        run_one(2'b10, 32'h0, 32'h0000BEEF, 2'd0, 2'd1, 3, 1'b0);
        run_one(2'b11, 32'h0000005A, 32'h000000A5, 2'd0, 2'd0, 1, 1'b0);
        run_one(2'b10, 32'h0, 32'h000000C3, 2'd0, 2'd0, 1, 1'b0);

        // Transmitter silent: timeout, then the next grant clears err.
        run_one(2'b01, 32'hDEADBEEF, 32'h0, 2'd2, 2'd0, -1, 1'b0);
        run_one(2'b01, 32'h00001234, 32'h0, 2'd1, 2'd0, 1, 1'b0);

        // Spurious Send_fin in IDLE and STROBE must not skip or repeat a byte.
        run_one(2'b01, 32'hCAFEF00D, 32'h0, 2'd3, 2'd0, 2, 1'b1);

        // Reset during the wait for byte 2.
        req_valid = 2'b01; req0_data = 32'h87654321; req0_len = 2'd3;
        #1;
        chk("mid_gnt", {30'd0, gnt}, 32'd1);
        @(negedge CLK); req_valid = '0; #1;
        chk("mid_b0", {24'd0, send_data}, 32'h21);
        @(negedge CLK); Send_fin = 1'b1;
        @(negedge CLK); Send_fin = 1'b0; #1;
        chk("mid_b1", {24'd0, send_data}, 32'h43);
        chk("mid_b1_valid", {31'd0, Sdata_valid}, 32'd1);
        @(negedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", {24'd0, send_data}, 32'd0);
        chk("mid_rst_done", {30'd0, done}, 32'd0);
        chk("mid_rst_valid", {31'd0, Sdata_valid}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK); #1;
            chk("mid_rst_nodone", {30'd0, done}, 32'd0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        favour = 0; exp_err = 1'b0;
        @(negedge CLK);
        run_one(2'b11, 32'h87654321, 32'h00000099, 2'd3, 2'd0, 2, 1'b0);

        // Random transfers against the reference arbitration and byte order.
        for (int k = 0; k < 20; k++) begin
            rd = $urandom;
            run_one(2'($urandom_range(1, 3)), $urandom, rd, 2'($urandom), 2'($urandom),
                    int'($urandom_range(1, 6)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL take parameter: TIMEOUT_CYC, default 32'd65535, max cycles from valid pulse to Send_fin before abort.
REQ-002 SHALL have port: CLK  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  2  per-requester request (bit0 = core MMIO, bit1 = debug), level, held until gnt.
REQ-005 SHALL have port: req0_data, req1_data  input  32 each  word to transmit, LSB byte first.
REQ-006 SHALL have port: req0_len, req1_len  input  2 each  byte count minus one (0 = 1 byte, 3 = 4 bytes).
REQ-007 SHALL have port: gnt  output  2  one-hot, one-cycle accept pulse; data/len sampled that cycle.
REQ-008 SHALL have port: done  output  2  one-hot, one-cycle pulse when granted transfer completes or aborts.
REQ-009 SHALL have port: send_data  output  8  byte to serial transmitter.
REQ-010 SHALL have port: Sdata_valid  output  1  one-cycle strobe to serial transmitter.
REQ-011 SHALL have port: Send_fin  input  1  one-cycle pulse from transmitter, byte finished.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: err  output  1  sticky timeout flag, cleared on next gnt.

Function
REQ-014 SHALL implement states IDLE, STROBE, WAIT, DONE.
REQ-015 IDLE: if any req_valid, SHALL grant by round-robin, pulse gnt, latch data to 32-bit shift reg, len to 2-bit counter, owner to 1-bit reg, go STROBE.
REQ-016 Round-robin: SHALL favour requester opposite last owner (reset: requester 0 favoured); single requester SHALL be granted regardless of pointer.
REQ-017 Pointer SHALL update only on gnt.
REQ-018 STROBE: SHALL drive Sdata_valid=1 for exactly one cycle with send_data=shift[7:0], clear timeout counter, go WAIT.
REQ-019 WAIT: on Send_fin with counter!=0, SHALL shift right 8, decrement counter, go STROBE; on Send_fin with counter==0, go DONE.
REQ-020 WAIT: if timeout counter reaches TIMEOUT_CYC without Send_fin, SHALL set err, go DONE (remaining bytes dropped).
REQ-021 DONE: SHALL pulse done[owner] one cycle, go IDLE; new grant earliest next cycle.
REQ-022 Send_fin outside WAIT SHALL be ignored.
REQ-023 send_data SHALL hold shift[7:0] at all times; Sdata_valid SHALL be 0 outside STROBE.
REQ-024 Latency: gnt to first Sdata_valid 1 cycle; last Send_fin to done 1 cycle; done to next gnt >=1 cycle.
REQ-025 req changes while busy SHALL not affect the transfer in flight.
REQ-026 Timeout counter SHALL be 32-bit, saturating, counting only in WAIT.

Reset
REQ-027 On RST_N low, SHALL go IDLE asynchronously; gnt=0, done=0, Sdata_valid=0, busy=0, err=0, send_data=8'h00, shift=0, counter=0, owner=0, pointer favours 0.
REQ-028 Reset mid-transfer SHALL abort with no done pulse; requester re-requests after reset.

Structure
REQ-029 State enum and byte-width/requester-count constants SHALL reside in shared package uart_pkg.
REQ-030 Round-robin pick SHALL be sub-module rr_arb2 (inputs req[1:0], last owner; output one-hot grant), combinational.
REQ-031 Transmitter SHALL be instantiated outside this block; connection is the send_data/Sdata_valid/Send_fin trio only.

Verification
REQ-032 req0 len=3 data=32'h44332211, Send_fin 5 cycles after each strobe -> send_data 11,22,33,44 in order, 4 strobes, done=2'b01 once.
REQ-033 req0 and req1 both valid from reset, len=0 -> gnt 01 first, then 10; repeat both -> order 01,10 alternating.
REQ-034 req1 alone, len=1 data=32'h0000BEEF -> bytes EF,BE; gnt=2'b10; pointer then favours 0.
REQ-035 TIMEOUT_CYC=16, Send_fin never returned -> err=1 after 16 WAIT cycles, done pulse, busy=0; next gnt clears err.
REQ-036 RST_N low during WAIT of byte 2 -> all outputs zero immediately, no done; post-reset transfer correct.
REQ-037 Spurious Send_fin in IDLE/STROBE -> no state change, no extra strobe.
